// File: rtl/mc_pkg.sv
// Shared encodings for the ARMv4 multicycle control unit: FSM states, ALU and
// datapath select codes, data-processing commands and condition codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_BRWB   = 4'd10
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_PC4    = 2'b10;

    localparam logic [1:0] SRCA_REG  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] REGSRC_DEF = 2'b00;
    localparam logic [1:0] REGSRC_RD  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
        logic       ir_write;
        logic       adr_src;
        logic [1:0] reg_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
    } ctrl_t;

    function automatic logic dp_legal(input logic [3:0] cmd);
        logic ok;
        case (cmd)
            CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP: ok = 1'b1;
            default:                                     ok = 1'b0;
        endcase
        return ok;
    endfunction

    // CMP shares the subtractor; only the writeback is suppressed
    function automatic logic [2:0] dp_alu(input logic [3:0] cmd);
        logic [2:0] alu;
        case (cmd)
            CMD_ADD: alu = ALU_ADD;
            CMD_SUB: alu = ALU_SUB;
            CMD_CMP: alu = ALU_SUB;
            CMD_AND: alu = ALU_AND;
            CMD_ORR: alu = ALU_ORR;
            default: alu = ALU_ADD;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-field evaluator: decides whether an instruction executes
// given the latched {N,Z,C,V} flags. Code 1111 never passes.
module cond_check
    import mc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n_s, z_s, c_s, v_s;
    assign {n_s, z_s, c_s, v_s} = flags;

    // Condition truth table
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z_s;
            COND_NE: pass = ~z_s;
            COND_CS: pass = c_s;
            COND_CC: pass = ~c_s;
            COND_MI: pass = n_s;
            COND_PL: pass = ~n_s;
            COND_VS: pass = v_s;
            COND_VC: pass = ~v_s;
            COND_HI: pass = c_s & ~z_s;
            COND_LS: pass = ~c_s | z_s;
            COND_GE: pass = (n_s == v_s);
            COND_LT: pass = (n_s != v_s);
            COND_GT: pass = ~z_s & (n_s == v_s);
            COND_LE: pass = z_s | (n_s != v_s);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARMv4 control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with the datapath controls decoded from State and Instr.
module mc_controller
    import mc_pkg::*;
#(
    parameter bit ENABLE_BL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic [3:0]  Flags,
    output logic [3:0]  State
);

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    ctrl_t      ctrl_s;
    ctrl_t      ctrl_gated_s;
    logic       cond_pass_s;

    logic [1:0] op_s;
    logic [3:0] cmd_s;
    logic       i_bit_s, s_bit_s, u_bit_s, l_bit_s, rd_pc_s, link_s, is_cmp_s;
    logic       unused_instr_s;

    assign op_s     = Instr[27:26];
    assign i_bit_s  = Instr[25];
    assign cmd_s    = Instr[24:21];
    assign u_bit_s  = Instr[23];
    assign s_bit_s  = Instr[20];
    assign l_bit_s  = Instr[20];
    assign rd_pc_s  = (Instr[15:12] == 4'd15);
    assign link_s   = Instr[24] & ENABLE_BL;
    assign is_cmp_s = (cmd_s == CMD_CMP);
    assign unused_instr_s = ^{Instr[19:16], Instr[11:0]};

    cond_check u_cond_check (
        .cond  (Instr[31:28]),
        .flags (flags_q),
        .pass  (cond_pass_s)
    );

    // Next-state and flag-latch selection
    always_comb begin
        state_d = S_FETCH;
        flags_d = flags_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (!cond_pass_s) begin
                    state_d = S_FETCH;
                end else begin
                    case (op_s)
                        OP_DP:   state_d = !dp_legal(cmd_s) ? S_FETCH
                                         : (i_bit_s ? S_EXECI : S_EXECR);
                        OP_MEM:  state_d = i_bit_s ? S_FETCH : S_MEMADR;
                        OP_BR:   state_d = i_bit_s ? S_BRANCH : S_FETCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_EXECR, S_EXECI: begin
                state_d = is_cmp_s ? S_FETCH : S_ALUWB;
                if (s_bit_s || is_cmp_s) begin
                    flags_d = ALUFlags;
                end else begin
                    flags_d = flags_q;
                end
            end
            S_ALUWB:  state_d = S_FETCH;
            S_MEMADR: state_d = l_bit_s ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = S_FETCH;
            S_BRANCH: state_d = S_BRWB;
            S_BRWB:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // State and condition-flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Moore output decode; fields not set stay zero
    always_comb begin
        ctrl_s = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_s.ir_write   = 1'b1;
                ctrl_s.pc_write   = 1'b1;
                ctrl_s.result_src = RES_PC4;
            end
            S_EXECR, S_EXECI: begin
                ctrl_s.alu_src_a   = SRCA_REG;
                ctrl_s.alu_src_b   = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
                ctrl_s.imm_src     = IMM_8;
                ctrl_s.alu_control = dp_alu(cmd_s);
            end
            S_ALUWB, S_MEMWB: begin
                ctrl_s.reg_write  = ~rd_pc_s;
                ctrl_s.result_src = (state_q == S_MEMWB) ? RES_DATA : RES_ALUOUT;
                ctrl_s.reg_src    = REGSRC_DEF;
            end
            S_MEMADR: begin
                ctrl_s.alu_src_b   = SRCB_IMM;
                ctrl_s.imm_src     = IMM_12;
                ctrl_s.alu_control = u_bit_s ? ALU_ADD : ALU_SUB;
            end
            S_MEMRD: ctrl_s.adr_src = 1'b1;
            S_MEMWR: begin
                ctrl_s.adr_src   = 1'b1;
                ctrl_s.mem_write = 1'b1;
                ctrl_s.reg_src   = REGSRC_RD;
            end
            S_BRANCH: begin
                ctrl_s.alu_src_a   = SRCA_PC;
                ctrl_s.alu_src_b   = SRCB_IMM;
                ctrl_s.imm_src     = IMM_24;
                ctrl_s.alu_control = ALU_ADD;
                if (link_s) begin
                    ctrl_s.reg_write  = 1'b1;
                    ctrl_s.reg_src    = REGSRC_RD;
                    ctrl_s.result_src = RES_PC4;
                end else begin
                    ctrl_s.reg_write  = 1'b0;
                end
            end
            S_BRWB: begin
                ctrl_s.pc_write   = 1'b1;
                ctrl_s.result_src = RES_ALUOUT;
            end
            default: ctrl_s = '0;
        endcase
    end

    // Reset kills every enable immediately, even though State already reads FETCH
    assign ctrl_gated_s = reset ? ctrl_s : '0;

    assign PCWrite    = ctrl_gated_s.pc_write;
    assign RegWrite   = ctrl_gated_s.reg_write;
    assign MemWrite   = ctrl_gated_s.mem_write;
    assign IRWrite    = ctrl_gated_s.ir_write;
    assign AdrSrc     = ctrl_gated_s.adr_src;
    assign RegSrc     = ctrl_gated_s.reg_src;
    assign ALUSrcA    = ctrl_gated_s.alu_src_a;
    assign ALUSrcB    = ctrl_gated_s.alu_src_b;
    assign ResultSrc  = ctrl_gated_s.result_src;
    assign ImmSrc     = ctrl_gated_s.imm_src;
    assign ALUControl = ctrl_gated_s.alu_control;
    assign Flags      = flags_q;
    assign State      = state_q;

endmodule
